// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a single-entry holding register.
// The line is synchronised, a falling edge opens a frame, every bit is
// sampled mid-bit, and a completed byte is handed to the consumer through
// a valid/ack level handshake with frame-error and overrun pulses.
module uart_rx #(
    parameter int unsigned CLKS_PER_BAUD = 434
) (
    input  logic       sys_clock,
    input  logic       reset_n,
    input  logic       i_uart_rx,
    input  logic       i_ack,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_overrun
);

    localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BAUD);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BAUD - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BAUD / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // Synchroniser and edge-detect history; all reset high so that an idle
    // line never looks like a start bit when reset is released.
    logic [1:0] sync_q;
    logic       prev_q;
    logic       line;
    logic       fall;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             cnt_zero;
    logic             done;

    assign line     = sync_q[1];
    assign fall     = prev_q & ~sync_q[1];
    assign cnt_zero = (cnt_q == '0);

    // Two-flop synchroniser plus one history flop for falling-edge detection.
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge value, so this chain shifts by exactly one stage per clock.
            sync_q <= {sync_q[0], i_uart_rx};
            prev_q <= sync_q[1];
        end
    end

    // Frame sequencing, bit sampling and holding-register / handshake update.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statements can leave one unassigned (no latches).
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        done        = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Only a falling edge opens a frame; a line stuck low does not.
                if (fall) begin
                    state_d = START;
                    cnt_d   = CNT_HALF;
                end
            end
            START: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (line) begin
                    state_d = IDLE;            // glitch: line back high mid-start
                end else begin
                    state_d   = DATA;
                    cnt_d     = CNT_FULL;
                    bit_idx_d = 3'd0;
                end
            end
            DATA: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    shift_d = {line, shift_q[7:1]};   // LSB arrives first
                    cnt_d   = CNT_FULL;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    state_d = IDLE;
                    if (line) begin
                        done = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A byte that completes while the old one is being acked replaces it;
        // otherwise a full holding register drops the new byte.
        if (done) begin
            if (!valid_q || i_ack) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (i_ack) begin
            valid_d = 1'b0;
        end
    end

    // State register for the receiver and the output holding register.
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;

endmodule
